// File: rtl/stereo_cam_config_sequencer.sv
// Stereo OV7670 configuration sequencer: powers both cameras up, then walks a
// shared register ROM once per camera through a single SCCB write engine.
module stereo_cam_config_sequencer #(
    parameter int unsigned ROM_AW        = 8,
    parameter int unsigned RESET_CYCLES  = 50000,
    parameter int unsigned SETTLE_CYCLES = 50000,
    parameter int unsigned DELAY_CYCLES  = 500000,
    parameter int unsigned ACK_TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              resend,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_start,
    input  logic              sccb_busy,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    output logic              cam_sel,
    output logic [1:0]        cam_reset_n,
    output logic [1:0]        cam_pwdn,
    output logic [1:0]        cfg_done,
    output logic [1:0]        cfg_err,
    output logic              cfg_busy
);

    localparam logic [15:0]       TokEnd   = 16'hFFFF;
    localparam logic [15:0]       TokDelay = 16'hF0F0;
    localparam logic [ROM_AW-1:0] AddrMax  = {ROM_AW{1'b1}};
    localparam logic [ROM_AW-1:0] AddrOne  = {{(ROM_AW-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        StPwr,
        StSettle,
        StFetch,
        StDecode,
        StDelay,
        StWaitAck,
        StWaitDone,
        StAdv,
        StNextCam,
        StDone,
        StRestart
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              start_q, start_d;
    logic [7:0]        reg_q, reg_d;
    logic [7:0]        val_q, val_d;
    logic              cam_sel_q, cam_sel_d;
    logic [1:0]        rst_n_q, rst_n_d;
    logic [1:0]        pwdn_q, pwdn_d;
    logic [1:0]        done_q, done_d;
    logic [1:0]        err_q, err_d;
    logic              pending_q, pending_d;
    logic              ack_expired;

    // One shared counter covers both WAITACK and WAITDONE, cleared when the write issues.
    assign ack_expired = (cnt_q == ACK_TIMEOUT - 1);

    // Next-state and next-value logic for the whole sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rom_addr_d = rom_addr_q;
        start_d    = 1'b0;
        reg_d      = reg_q;
        val_d      = val_q;
        cam_sel_d  = cam_sel_q;
        rst_n_d    = rst_n_q;
        pwdn_d     = pwdn_q;
        done_d     = done_q;
        err_d      = err_q;
        pending_d  = pending_q;

        // Resend during a table walk is deferred to the next ADV so a write is never cut short.
        if (resend && (state_q inside {StFetch, StDecode, StDelay, StWaitAck, StWaitDone,
                                       StAdv, StNextCam})) begin
            pending_d = 1'b1;
        end

        case (state_q)
            StPwr: begin
                pwdn_d  = 2'b00;
                rst_n_d = 2'b00;
                if (cnt_q == RESET_CYCLES) begin
                    rst_n_d = 2'b11;
                    cnt_d   = '0;
                    state_d = StSettle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StSettle: begin
                if (cnt_q == SETTLE_CYCLES - 1) begin
                    cnt_d      = '0;
                    rom_addr_d = '0;
                    cam_sel_d  = 1'b0;
                    state_d    = StFetch;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StFetch: begin
                state_d = StDecode;
            end
            StDecode: begin
                cnt_d = '0;
                if (rom_data == TokEnd) begin
                    done_d[cam_sel_q] = 1'b1;
                    state_d           = StNextCam;
                end else if (rom_data == TokDelay) begin
                    state_d = StDelay;
                end else begin
                    reg_d   = rom_data[15:8];
                    val_d   = rom_data[7:0];
                    start_d = 1'b1;
                    state_d = StWaitAck;
                end
            end
            StDelay: begin
                if (cnt_q == DELAY_CYCLES - 1) begin
                    state_d = StAdv;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StWaitAck: begin
                cnt_d = cnt_q + 32'd1;
                if (ack_expired) begin
                    err_d[cam_sel_q] = 1'b1;
                    state_d          = StAdv;
                end else if (sccb_busy) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                cnt_d = cnt_q + 32'd1;
                if (ack_expired) begin
                    err_d[cam_sel_q] = 1'b1;
                    state_d          = StAdv;
                end else if (!sccb_busy) begin
                    state_d = StAdv;
                end
            end
            StAdv: begin
                // A table without a terminator stops at the last entry instead of wrapping.
                if (rom_addr_q == AddrMax) begin
                    state_d = StNextCam;
                end else begin
                    rom_addr_d = rom_addr_q + AddrOne;
                    state_d    = pending_q ? StRestart : StFetch;
                end
            end
            StNextCam: begin
                done_d[cam_sel_q] = 1'b1;
                if (!cam_sel_q) begin
                    cam_sel_d  = 1'b1;
                    rom_addr_d = '0;
                    state_d    = StFetch;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (resend || pending_q) begin
                    state_d = StRestart;
                end
            end
            StRestart: begin
                done_d     = 2'b00;
                err_d      = 2'b00;
                rom_addr_d = '0;
                cam_sel_d  = 1'b0;
                pending_d  = 1'b0;
                state_d    = StFetch;
            end
            default: begin
                state_d = StPwr;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StPwr;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q      <= '0;
            rom_addr_q <= '0;
            start_q    <= 1'b0;
            reg_q      <= '0;
            val_q      <= '0;
            cam_sel_q  <= 1'b0;
            rst_n_q    <= 2'b00;
            pwdn_q     <= 2'b11;
            done_q     <= 2'b00;
            err_q      <= 2'b00;
            pending_q  <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            rom_addr_q <= rom_addr_d;
            start_q    <= start_d;
            reg_q      <= reg_d;
            val_q      <= val_d;
            cam_sel_q  <= cam_sel_d;
            rst_n_q    <= rst_n_d;
            pwdn_q     <= pwdn_d;
            done_q     <= done_d;
            err_q      <= err_d;
            pending_q  <= pending_d;
        end
    end

    assign rom_addr    = rom_addr_q;
    assign sccb_start  = start_q;
    assign sccb_reg    = reg_q;
    assign sccb_val    = val_q;
    assign cam_sel     = cam_sel_q;
    assign cam_reset_n = rst_n_q;
    assign cam_pwdn    = pwdn_q;
    assign cfg_done    = done_q;
    assign cfg_err     = err_q;
    assign cfg_busy    = (state_q != StDone);

endmodule

// File: tb/tb_stereo_cam_config_sequencer.sv
// Bench for stereo_cam_config_sequencer: ROM and SCCB engine models, a write
// monitor, and a table-level reference model of the expected write sequence.
module tb_stereo_cam_config_sequencer;

    localparam int unsigned ROM_AW     = 2;
    localparam int unsigned RESET_CYC  = 10;
    localparam int unsigned SETTLE_CYC = 10;
    localparam int unsigned DELAY_CYC  = 100;
    localparam int unsigned ACK_TO     = 32;
    localparam int          NROM       = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              resend;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data;
    logic              sccb_start;
    logic              sccb_busy;
    logic [7:0]        sccb_reg;
    logic [7:0]        sccb_val;
    logic              cam_sel;
    logic [1:0]        cam_reset_n;
    logic [1:0]        cam_pwdn;
    logic [1:0]        cfg_done;
    logic [1:0]        cfg_err;
    logic              cfg_busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] rom [NROM];
    logic [16:0] obs_q [$];
    logic [16:0] exp_q [$];
    logic [16:0] hold_v;
    logic        prev_start;
    bit          eng_dead;
    int          busy_len;
    bit          eng_pend;
    int          eng_rem;

    always #5 clk = ~clk;

    stereo_cam_config_sequencer #(
        .ROM_AW        (ROM_AW),
        .RESET_CYCLES  (RESET_CYC),
        .SETTLE_CYCLES (SETTLE_CYC),
        .DELAY_CYCLES  (DELAY_CYC),
        .ACK_TIMEOUT   (ACK_TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .resend      (resend),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .sccb_start  (sccb_start),
        .sccb_busy   (sccb_busy),
        .sccb_reg    (sccb_reg),
        .sccb_val    (sccb_val),
        .cam_sel     (cam_sel),
        .cam_reset_n (cam_reset_n),
        .cam_pwdn    (cam_pwdn),
        .cfg_done    (cfg_done),
        .cfg_err     (cfg_err),
        .cfg_busy    (cfg_busy)
    );

    // Synchronous ROM, one cycle read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SCCB engine: busy rises 1 or 2 cycles after start and lasts busy_len cycles.
    always @(posedge clk) begin
        if (reset) begin
            sccb_busy <= 1'b0;
            eng_pend  <= 1'b0;
            eng_rem   <= 0;
        end else if (sccb_start && !eng_dead) begin
            if ($urandom_range(0, 1) == 0) begin
                sccb_busy <= 1'b1;
                eng_rem   <= busy_len - 1;
            end else begin
                eng_pend <= 1'b1;
            end
        end else if (eng_pend) begin
            sccb_busy <= 1'b1;
            eng_rem   <= busy_len - 1;
            eng_pend  <= 1'b0;
        end else if (sccb_busy) begin
            if (eng_rem == 0) sccb_busy <= 1'b0;
            else eng_rem <= eng_rem - 1;
        end
    end

    // Write monitor: records every issued write and checks hold rules while busy.
    always @(negedge clk) begin
        if (sccb_start) begin
            obs_q.push_back({cam_sel, sccb_reg, sccb_val});
            hold_v = {cam_sel, sccb_reg, sccb_val};
            checks++;
            if (prev_start === 1'b1) begin
                errors++;
                $display("FAIL start_width: sccb_start high two cycles in a row at %0t", $time);
            end
        end else if (sccb_busy) begin
            checks++;
            if ({cam_sel, sccb_reg, sccb_val} !== hold_v) begin
                errors++;
                $display("FAIL hold: got %h expected %h while busy",
                         {cam_sel, sccb_reg, sccb_val}, hold_v);
            end
        end
        prev_start = sccb_start;
    end

    // Reference: left camera then right camera walk the table up to the terminator.
    function automatic void model_fill();
        exp_q.delete();
        for (int cam = 0; cam < 2; cam++) begin
            for (int i = 0; i < NROM; i++) begin
                if (rom[i] == 16'hFFFF) break;
                if (rom[i] == 16'hF0F0) continue;
                exp_q.push_back({cam[0], rom[i]});
            end
        end
    endfunction

    function automatic logic [15:0] rand_entry();
        logic [15:0] e;
        do e = 16'($urandom); while (e == 16'hFFFF || e == 16'hF0F0);
        return e;
    endfunction

    task automatic wait_idle(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!cfg_busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Pulse resend from DONE and return the negedge count at which sccb_start appears.
    task automatic restart_and_time(input int limit, output int n);
        obs_q.delete();
        @(negedge clk);
        resend = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) resend = 1'b0;
        end while (!sccb_start && n < limit);
    endtask

    task automatic test_reset();
        int  n;
        bit  pwdn_bad;
        bit  ok;
        reset    = 1'b1;
        resend   = 1'b0;
        eng_dead = 1'b0;
        busy_len = 20;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({rom_addr, sccb_start, sccb_reg, sccb_val, cam_sel} !== '0) begin
            errors++;
            $display("FAIL reset_datapath: got %h expected 0",
                     {rom_addr, sccb_start, sccb_reg, sccb_val, cam_sel});
        end
        checks++;
        if ({cam_reset_n, cam_pwdn} !== 4'b0011) begin
            errors++;
            $display("FAIL reset_cam_pins: got %b expected 0011", {cam_reset_n, cam_pwdn});
        end
        checks++;
        if ({cfg_done, cfg_err, cfg_busy} !== 5'b00001) begin
            errors++;
            $display("FAIL reset_status: got %b expected 00001", {cfg_done, cfg_err, cfg_busy});
        end
        obs_q.delete();
        reset = 1'b0;
        n = 0;
        pwdn_bad = 1'b0;
        @(negedge clk);
        while (cam_reset_n == 2'b00 && n < 100) begin
            if (cam_pwdn !== 2'b00) pwdn_bad = 1'b1;
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != RESET_CYC) begin
            errors++;
            $display("FAIL pwr_cycles: reset_n low %0d cycles expected %0d", n, RESET_CYC);
        end
        checks++;
        if (pwdn_bad || cam_pwdn !== 2'b00) begin
            errors++;
            $display("FAIL pwdn: cam_pwdn not 00 during power-up, now %b expected 00", cam_pwdn);
        end
        // A resend during SETTLE must be ignored.
        resend = 1'b1;
        n = 0;
        while (!sccb_start && n < 100) begin
            @(negedge clk);
            n++;
            if (n == 1) resend = 1'b0;
            if (!sccb_start && cam_reset_n !== 2'b11) pwdn_bad = 1'b1;
        end
        checks++;
        if (n != SETTLE_CYC + 2 || pwdn_bad) begin
            errors++;
            $display("FAIL settle_cycles: first start after %0d cycles expected %0d",
                     n, SETTLE_CYC + 2);
        end
        wait_idle(5000, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL powerup_idle: cfg_busy still %b expected 0", cfg_busy);
        end
    endtask

    task automatic test_two_write();
        model_fill();
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL two_write_len: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL two_write[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({cfg_done, cfg_err, cfg_busy} !== 5'b11000) begin
            errors++;
            $display("FAIL two_write_status: got %b expected 11000", {cfg_done, cfg_err, cfg_busy});
        end
    endtask

    task automatic test_delay();
        int n;
        bit ok;
        rom[0] = 16'hF0F0; rom[1] = 16'h1280; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        model_fill();
        restart_and_time(1000, n);
        // RESTART, FETCH, DECODE, DELAY x N, ADV, FETCH, DECODE, then start.
        checks++;
        if (n != 4 + DELAY_CYC + 3) begin
            errors++;
            $display("FAIL delay_gap: start after %0d cycles expected %0d", n, 4 + DELAY_CYC + 3);
        end
        wait_idle(5000, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL delay_len: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL delay_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        int k;
        bit ok;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'hFFFF; rom[3] = 16'h0000;
        model_fill();
        eng_dead = 1'b1;
        restart_and_time(100, n);
        k = 0;
        while (!cfg_err[0] && k < 200) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != ACK_TO) begin
            errors++;
            $display("FAIL timeout_cycles: cfg_err[0] after %0d cycles expected %0d", k, ACK_TO);
        end
        wait_idle(5000, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL timeout_len: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL timeout_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if ({cfg_done, cfg_err} !== 4'b1111) begin
            errors++;
            $display("FAIL timeout_status: got %b expected 1111", {cfg_done, cfg_err});
        end
        eng_dead = 1'b0;
    endtask

    task automatic test_resend_mid();
        int          n;
        bit          ok;
        logic [16:0] w0;
        logic [16:0] w1;
        rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h1234; rom[3] = 16'hFFFF;
        model_fill();
        w0 = exp_q[0];
        w1 = exp_q[1];
        exp_q.push_front(w1);
        exp_q.push_front(w0);
        busy_len = 12;
        obs_q.delete();
        @(negedge clk);
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        @(negedge clk);
        checks++;
        if (cfg_done !== 2'b00 || cfg_err !== 2'b00) begin
            errors++;
            $display("FAIL restart_clear: done/err %b expected 0000", {cfg_done, cfg_err});
        end
        n = 2;
        while (!sccb_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL restart_gap: start after %0d cycles expected 4", n);
        end
        n = 0;
        while (!(obs_q.size() == 2 && sccb_busy) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 500) begin
            errors++;
            $display("FAIL resend_wait: second write busy not seen, writes %0d expected 2",
                     obs_q.size());
        end
        resend = 1'b1;
        @(negedge clk);
        resend = 1'b0;
        wait_idle(5000, ok);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL resend_len: got %0d writes expected %0d", obs_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL resend_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (cfg_done !== 2'b11) begin
            errors++;
            $display("FAIL resend_done: got %b expected 11", cfg_done);
        end
    endtask

    task automatic test_rom_end();
        int n;
        int left;
        bit ok;
        for (int i = 0; i < NROM; i++) rom[i] = rand_entry();
        model_fill();
        busy_len = 5;
        restart_and_time(100, n);
        wait_idle(5000, ok);
        left = 0;
        foreach (obs_q[i]) if (obs_q[i][16] == 1'b0) left++;
        checks++;
        if (!ok || obs_q.size() != 2 * NROM || left != NROM) begin
            errors++;
            $display("FAIL rom_end_count: got %0d writes (%0d left) expected %0d (%0d left)",
                     obs_q.size(), left, 2 * NROM, NROM);
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL rom_end_seq[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        bit ok;
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < NROM; i++) begin
                case ($urandom_range(0, 7))
                    0:       rom[i] = 16'hFFFF;
                    1:       rom[i] = 16'hF0F0;
                    default: rom[i] = rand_entry();
                endcase
            end
            busy_len = $urandom_range(1, 25);
            model_fill();
            restart_and_time(1000, n);
            wait_idle(5000, ok);
            checks++;
            if (!ok || obs_q.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_len: got %0d writes expected %0d",
                         it, obs_q.size(), exp_q.size());
            end else begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    checks++;
                    if (obs_q[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_seq[%0d]: got %h expected %h",
                                 it, i, obs_q[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if ({cfg_done, cfg_err} !== 4'b1100) begin
                errors++;
                $display("FAIL rand%0d_status: got %b expected 1100", it, {cfg_done, cfg_err});
            end
        end
    endtask

    initial begin
        test_reset();
        test_two_write();
        test_delay();
        test_timeout();
        test_resend_mid();
        test_rom_end();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
